pingpong_buf_ctrl: RTL and testbench

//  Ping-pong buffer controller between the modulation mapper and the transform-precoding stage.
//  - Steers mapper writes into symbol bank A or B.
//  - Tracks each bank's fill length and fill/drain state.
//  - Drains completed banks to the downstream reader over a valid/ready handshake.
//  - Flags overflow when the writer catches the reader.

---
 rtl/pingpong_buf_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pingpong_buf_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong symbol buffer controller: steers mapper writes into bank A/B and drains closed banks.
// Optional overflow drop counter (Ovf_cnt) is built when PP_OVF_CNT_EN is defined.
module pingpong_buf_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_LEN    = 1200,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK_PP,
  input  logic                  RST_PP,
  input  logic                  Wr_valid,
  input  logic [ADDR_WIDTH-1:0] Wr_addr_in,
  input  logic                  Mod_done,
  input  logic [ADDR_WIDTH-1:0] Last_addr,
  input  logic                  Rd_ready,
  input  logic                  Clr_ovf,
  output logic                  Wr_en_A,
  output logic                  Wr_en_B,
  output logic [ADDR_WIDTH-1:0] Wr_addr_out,
  output logic [ADDR_WIDTH-1:0] Rd_addr,
  output logic                  Rd_bank,
  output logic                  Rd_valid,
  output logic                  Rd_last,
  output logic [ADDR_WIDTH-1:0] Blk_len,
  output logic                  Overflow,
  output logic                  Busy
`ifdef PP_OVF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  Ovf_cnt
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] MAX_LEN_V = ADDR_WIDTH'(MAX_LEN);

  logic [1:0][1:0]            state_reg, state_next;
  logic [1:0][ADDR_WIDTH-1:0] len_reg, len_next;
  logic                       wb_reg, wb_next;
  logic                       rb_reg, rb_next;
  logic [1:0]                 wr_en_reg, wr_en_next;
  logic [ADDR_WIDTH-1:0]      wr_addr_reg, wr_addr_next;
  logic                       rd_valid_reg, rd_valid_next;
  logic [ADDR_WIDTH-1:0]      rd_addr_reg, rd_addr_next;
  logic                       rd_bank_reg, rd_bank_next;
  logic [ADDR_WIDTH-1:0]      blk_len_reg, blk_len_next;
  logic                       overflow_reg, overflow_next;
  logic                       busy_reg, busy_next;

  logic                       wb_open;
  logic                       wr_drop;
  logic                       rd_last;
  logic                       rb_other;
  logic [ADDR_WIDTH-1:0]      close_len;

`ifdef PP_OVF_CNT_EN
  logic [CNT_WIDTH-1:0]       ovf_cnt_reg, ovf_cnt_next;
`else
  logic                       unused_cnt_width;
  assign unused_cnt_width = ^CNT_WIDTH;
`endif

  assign wb_open   = (state_reg[wb_reg] == ST_EMPTY) || (state_reg[wb_reg] == ST_FILL);
  assign wr_drop   = Wr_valid && !wb_open;
  assign rb_other  = ~rb_reg;
  assign close_len = (Last_addr > MAX_LEN_V) ? MAX_LEN_V : Last_addr;
  assign rd_last   = rd_valid_reg && (rd_addr_reg == blk_len_reg - ADDR_WIDTH'(1));

  always_ff @(posedge CLK_PP) begin
    if (RST_PP) begin
      state_reg    <= '0;
      len_reg      <= '0;
      wb_reg       <= 1'b0;
      rb_reg       <= 1'b0;
      wr_en_reg    <= '0;
      wr_addr_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_addr_reg  <= '0;
      rd_bank_reg  <= 1'b0;
      blk_len_reg  <= '0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
`ifdef PP_OVF_CNT_EN
      ovf_cnt_reg  <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      wb_reg       <= wb_next;
      rb_reg       <= rb_next;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      rd_valid_reg <= rd_valid_next;
      rd_addr_reg  <= rd_addr_next;
      rd_bank_reg  <= rd_bank_next;
      blk_len_reg  <= blk_len_next;
      overflow_reg <= overflow_next;
      busy_reg     <= busy_next;
`ifdef PP_OVF_CNT_EN
      ovf_cnt_reg  <= ovf_cnt_next;
`endif
    end
  end

  // Write side only touches EMPTY/FILL banks, read side only FULL/DRAIN, so they never collide.
  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    wb_next       = wb_reg;
    rb_next       = rb_reg;
    wr_en_next    = '0;
    wr_addr_next  = Wr_addr_in;
    rd_valid_next = rd_valid_reg;
    rd_addr_next  = rd_addr_reg;
    rd_bank_next  = rd_bank_reg;
    blk_len_next  = blk_len_reg;
    overflow_next = overflow_reg;

    if (Wr_valid && wb_open) begin
      wr_en_next[wb_reg] = 1'b1;
      state_next[wb_reg] = ST_FILL;
    end

    // Close decision uses the pre-write state, so a same-cycle write lands in the closing bank.
    if (Mod_done && (state_reg[wb_reg] == ST_FILL)) begin
      if (close_len != '0) begin
        state_next[wb_reg] = ST_FULL;
        len_next[wb_reg]   = close_len;
        wb_next            = ~wb_reg;
      end else begin
        state_next[wb_reg] = ST_EMPTY;
      end
    end

    if (!rd_valid_reg) begin
      if (state_reg[rb_reg] == ST_FULL) begin
        state_next[rb_reg] = ST_DRAIN;
        rd_valid_next      = 1'b1;
        rd_addr_next       = '0;
        rd_bank_next       = rb_reg;
        blk_len_next       = len_reg[rb_reg];
      end
    end else if (Rd_ready) begin
      if (rd_last) begin
        state_next[rb_reg] = ST_EMPTY;
        rb_next            = rb_other;
        if (state_reg[rb_other] == ST_FULL) begin
          state_next[rb_other] = ST_DRAIN;
          rd_addr_next         = '0;
          rd_bank_next         = rb_other;
          blk_len_next         = len_reg[rb_other];
        end else begin
          rd_valid_next = 1'b0;
        end
      end else begin
        rd_addr_next = rd_addr_reg + ADDR_WIDTH'(1);
      end
    end

    if (Clr_ovf) begin
      overflow_next = 1'b0;
    end else if (wr_drop) begin
      overflow_next = 1'b1;
    end

    busy_next = (state_next[0] != ST_EMPTY) || (state_next[1] != ST_EMPTY);
  end

`ifdef PP_OVF_CNT_EN
  always_comb begin
    ovf_cnt_next = ovf_cnt_reg;
    if (Clr_ovf) begin
      ovf_cnt_next = '0;
    end else if (wr_drop && (ovf_cnt_reg != '1)) begin
      ovf_cnt_next = ovf_cnt_reg + CNT_WIDTH'(1);
    end
  end
`endif

  always_comb begin
    Wr_en_A     = wr_en_reg[0];
    Wr_en_B     = wr_en_reg[1];
    Wr_addr_out = wr_addr_reg;
    Rd_addr     = rd_addr_reg;
    Rd_bank     = rd_bank_reg;
    Rd_valid    = rd_valid_reg;
    Rd_last     = rd_last;
    Blk_len     = blk_len_reg;
    Overflow    = overflow_reg;
    Busy        = busy_reg;
`ifdef PP_OVF_CNT_EN
    Ovf_cnt     = ovf_cnt_reg;
`endif
  end

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Scoreboard bench for pingpong_buf_ctrl: a block-level model predicts writes, drained symbols and flags.
// Define PP_OVF_CNT_EN to also check the overflow drop counter.
`timescale 1ns/1ps
module tb_pingpong_buf_ctrl;
  localparam int AW   = 11;
  localparam int MAXL = 1200;
  localparam int CW   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_pp = 1'b1, wr_valid = 1'b0, mod_done = 1'b0, rd_ready = 1'b1, clr_ovf = 1'b0;
  logic [AW-1:0] wr_addr_in = '0, last_addr = '0;
  logic          wr_en_a, wr_en_b, rd_bank, rd_valid, rd_last, overflow, busy;
  logic [AW-1:0] wr_addr_out, rd_addr, blk_len;
`ifdef PP_OVF_CNT_EN
  logic [CW-1:0] ovf_cnt;
`endif

  pingpong_buf_ctrl #(.ADDR_WIDTH(AW), .MAX_LEN(MAXL), .CNT_WIDTH(CW)) dut (
    .CLK_PP(clk), .RST_PP(rst_pp), .Wr_valid(wr_valid), .Wr_addr_in(wr_addr_in),
    .Mod_done(mod_done), .Last_addr(last_addr), .Rd_ready(rd_ready), .Clr_ovf(clr_ovf),
    .Wr_en_A(wr_en_a), .Wr_en_B(wr_en_b), .Wr_addr_out(wr_addr_out), .Rd_addr(rd_addr),
    .Rd_bank(rd_bank), .Rd_valid(rd_valid), .Rd_last(rd_last), .Blk_len(blk_len),
    .Overflow(overflow), .Busy(busy)
`ifdef PP_OVF_CNT_EN
    , .Ovf_cnt(ovf_cnt)
`endif
  );

  typedef struct { int bank; int addr; } wr_t;
  typedef struct { int bank; int addr; int last; int len; } rd_t;
  typedef struct { int rd_valid; int ovf; int busy; int cnt; } fl_t;
  typedef struct { int bank; int len; int close_step; } blk_t;

  wr_t  wr_q[$];
  rd_t  rd_q[$];
  fl_t  fl_q[$];
  blk_t m_blocks[$];   // closed blocks awaiting or under drain, oldest first

  int n_checks = 0;
  int n_fail   = 0;

  int m_step = 0, m_wb = 0, m_rd_pos = 0, m_cnt = 0;
  bit m_open[2], m_held[2], m_rd_active = 0, m_ovf = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predicts the effect of the upcoming clock edge from the inputs currently driven.
  task automatic model_step();
    int  wb0, len;
    bit  fill_before, drop;
    if (rst_pp) begin
      m_wb = 0; m_open = '{0, 0}; m_held = '{0, 0};
      m_blocks.delete(); m_rd_active = 0; m_rd_pos = 0; m_ovf = 0; m_cnt = 0;
      fl_q.push_back('{0, 0, 0, 0});
      m_step++;
      return;
    end
    wb0 = m_wb;
    fill_before = m_open[wb0];
    drop = 0;
    if (wr_valid) begin
      if (m_held[wb0]) drop = 1;
      else begin
        wr_q.push_back('{wb0, int'(wr_addr_in)});
        m_open[wb0] = 1;
      end
    end
    if (mod_done && fill_before) begin
      len = (int'(last_addr) > MAXL) ? MAXL : int'(last_addr);
      m_open[wb0] = 0;
      if (len != 0) begin
        m_held[wb0] = 1;
        m_blocks.push_back('{wb0, len, m_step});
        m_wb = 1 - m_wb;
      end
    end
    if (m_rd_active) begin
      if (rd_ready) begin
        rd_q.push_back('{m_blocks[0].bank, m_rd_pos, int'(m_rd_pos == m_blocks[0].len - 1), m_blocks[0].len});
        m_rd_pos++;
        if (m_rd_pos == m_blocks[0].len) begin
          m_held[m_blocks[0].bank] = 0;
          void'(m_blocks.pop_front());
          m_rd_active = 0;
          if (m_blocks.size() > 0 && m_blocks[0].close_step < m_step) begin
            m_rd_active = 1; m_rd_pos = 0;
          end
        end
      end
    end else if (m_blocks.size() > 0 && m_blocks[0].close_step < m_step) begin
      m_rd_active = 1; m_rd_pos = 0;
    end
    if (clr_ovf) begin
      m_ovf = 0; m_cnt = 0;
    end else if (drop) begin
      m_ovf = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end
    fl_q.push_back('{int'(m_rd_active), int'(m_ovf),
                     int'(m_open[0] | m_open[1] | m_held[0] | m_held[1]), m_cnt});
    m_step++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    wr_valid = 0; mod_done = 0; clr_ovf = 0; rst_pp = 0;
  endtask

  task automatic write_block(input int n, input int last, input bit coincide);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1;
      wr_addr_in = AW'($urandom_range(0, 2047));
      if (coincide && i == n - 1) begin
        mod_done = 1; last_addr = AW'(last);
      end
      tick();
    end
    if (!coincide) begin
      mod_done = 1; last_addr = AW'(last);
      tick();
    end
  endtask

  task automatic wait_idle(input int budget);
    int i;
    rd_ready = 1;
    for (i = 0; i < budget && (m_blocks.size() > 0 || m_rd_active); i++) tick();
    if (m_blocks.size() > 0 || m_rd_active) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: model still busy after %0d cycles", budget);
    end
    tick(); tick();
  endtask

  // Monitor: mid-cycle sampling of outputs, popping expectations in order.
  initial begin
    fl_t f;
    wr_t w;
    rd_t r;
    forever begin
      @(negedge clk);
      if (fl_q.size() > 0) begin
        f = fl_q.pop_front();
        check("rd_valid", int'(rd_valid), f.rd_valid);
        check("overflow", int'(overflow), f.ovf);
        check("busy", int'(busy), f.busy);
`ifdef PP_OVF_CNT_EN
        check("ovf_cnt", int'(ovf_cnt), f.cnt);
`endif
      end
      if (wr_en_a || wr_en_b) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          w = wr_q.pop_front();
          $display("write bank=%0d addr=%0d", w.bank, w.addr);
          check("wr_en_a", int'(wr_en_a), int'(w.bank == 0));
          check("wr_en_b", int'(wr_en_b), int'(w.bank == 1));
          check("wr_addr_out", int'(wr_addr_out), w.addr);
        end
      end
      if (rd_valid && rd_ready && !rst_pp) begin
        if (rd_q.size() == 0) begin
          check("unexpected_read", 1, 0);
        end else begin
          r = rd_q.pop_front();
          if (r.addr == 0 || r.last != 0)
            $display("read bank=%0d addr=%0d len=%0d last=%0d", r.bank, r.addr, r.len, r.last);
          check("rd_bank", int'(rd_bank), r.bank);
          check("rd_addr", int'(rd_addr), r.addr);
          check("rd_last", int'(rd_last), r.last);
          check("blk_len", int'(blk_len), r.len);
        end
      end
    end
  end

  initial begin
    // Reset
    rst_pp = 1; tick();
    rst_pp = 1; tick();
    // Single 300-symbol block, reader always ready
    rd_ready = 1;
    write_block(300, 300, 0);
    wait_idle(2000);
    // Back-to-back 1200 then 600 with a 50-cycle reader stall while B fills
    write_block(1200, 1200, 0);
    for (int i = 0; i < 600; i++) begin
      rd_ready = (i >= 50);
      wr_valid = 1; wr_addr_in = AW'($urandom_range(0, 2047));
      if (i == 599) begin mod_done = 1; last_addr = AW'(600); end
      tick();
    end
    wait_idle(4000);
    // Overflow with both banks occupied, then clear (clear wins over a same-cycle drop)
    rd_ready = 0;
    write_block(10, 10, 0);
    write_block(10, 10, 0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_addr_in = AW'(i); tick();
    end
    mod_done = 1; last_addr = AW'(3); tick();
    tick();
    clr_ovf = 1; wr_valid = 1; tick();
    tick();
    wait_idle(200);
    // Clamp to MAX_LEN, zero-length close, then reuse of the same bank
    write_block(20, 1500, 0);
    wait_idle(3000);
    write_block(5, 0, 0);
    write_block(7, 7, 0);
    wait_idle(200);
    // Close coincident with the final write
    write_block(8, 8, 1);
    write_block(4, 4, 1);
    wait_idle(200);
    // Reset in the middle of a drain at Rd_addr=100
    write_block(300, 300, 0);
    for (int i = 0; i < 2000 && !(m_rd_active && m_rd_pos == 100); i++) tick();
    rst_pp = 1; tick();
    write_block(10, 10, 0);
    wait_idle(200);
    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      wr_valid   = ($urandom_range(0, 9) < 7);
      wr_addr_in = AW'($urandom_range(0, 2047));
      rd_ready   = ($urandom_range(0, 3) != 0);
      clr_ovf    = ($urandom_range(0, 99) == 0);
      mod_done   = ($urandom_range(0, 29) == 0);
      last_addr  = ($urandom_range(0, 39) == 0) ? AW'(1300 + $urandom_range(0, 700))
                                                : AW'($urandom_range(0, 60));
      rst_pp     = ($urandom_range(0, 1999) == 0);
      tick();
    end
    wait_idle(5000);
    check("wr_queue_empty", wr_q.size(), 0);
    check("rd_queue_empty", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
